pad_ctl_scheduler: RTL and testbench



---
 rtl/pad_ctl_pkg.sv | 18 +
 rtl/pad_ctl_stagger_cnt.sv | 38 +++
 rtl/pad_ctl_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_pad_ctl_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_ctl_pkg.sv
// Shared types and constants for the pad control scheduler: FSM state
// encoding, default geometry and the pad-to-slice offset helper.
package pad_ctl_pkg;

   localparam int PAD_CTL_W_DEF = 9;
   localparam int FIRST_PAD_DEF = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      WAIT = 2'd2
   } pad_ctl_state_t;

   function automatic int pad_ctl_offset(input int pad, input int first_pad, input int ctl_w);
      return (pad - first_pad) * ctl_w;
   endfunction

endpackage

// File: rtl/pad_ctl_stagger_cnt.sv
// Loadable down-counter that spaces successive live pad updates.
// zero flags that the count reaches zero with this cycle's decrement.
module pad_ctl_stagger_cnt
   import pad_ctl_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_n;

   always_comb begin
      cnt_n = cnt;
      if (load) begin
         cnt_n = load_val;
      end else if (dec && (cnt != '0)) begin
         cnt_n = cnt - 1'b1;
      end
   end

   assign zero = (cnt_n == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_n;
      end
   end

endmodule

// File: rtl/pad_ctl_scheduler.sv
// Shadow/live pad control words with a staggered apply sequence.
// Define PAD_CTL_STAGGER_EN for one-pad-at-a-time updates; otherwise all pads update at once.
//
//   state | meaning
//   IDLE  | waiting for apply_req; config writes accepted
//   SCAN  | compare shadow[idx] with live[idx], copy if different
//   WAIT  | stagger delay after a copied pad
module pad_ctl_scheduler
   import pad_ctl_pkg::*;
#(
   parameter int                   NUM_PADS    = 11,
   parameter int                   FIRST_PAD   = FIRST_PAD_DEF,
   parameter int                   PAD_CTL_W   = PAD_CTL_W_DEF,
   parameter int                   STAGGER_CYC = 4,
   parameter logic [PAD_CTL_W-1:0] RESET_CTL   = '0,
   localparam int                  AW          = $clog2(NUM_PADS),
   localparam int                  NC          = NUM_PADS - FIRST_PAD
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [AW-1:0]           cfg_addr,
   input  logic [PAD_CTL_W-1:0]    cfg_data,
   output logic                    cfg_err,
   input  logic                    apply_req,
   output logic                    busy,
   output logic                    done,
   output logic [NC*PAD_CTL_W-1:0] pad_ctl_o
);

   pad_ctl_state_t state, state_n;
   logic pending, pending_n;
   logic done_q, done_n;
   logic err_q;
   logic addr_ok, wr_en, pend_eff;
   logic [PAD_CTL_W-1:0] shadow [FIRST_PAD:NUM_PADS-1];
   logic [PAD_CTL_W-1:0] live   [FIRST_PAD:NUM_PADS-1];

   assign busy      = (state != IDLE);
   assign cfg_ready = !busy;
   assign cfg_err   = err_q;
   assign done      = done_q;
   assign addr_ok   = (cfg_addr >= AW'(FIRST_PAD)) && (cfg_addr <= AW'(NUM_PADS - 1));
   assign wr_en     = cfg_valid && cfg_ready;
   // A request arriving in the final busy cycle still counts as pending.
   assign pend_eff  = pending || apply_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pending <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int p = FIRST_PAD; p < NUM_PADS; p++) begin
            shadow[p] <= RESET_CTL;
         end
      end else begin
         state   <= state_n;
         pending <= pending_n;
         done_q  <= done_n;
         err_q   <= wr_en && !addr_ok;
         if (wr_en && addr_ok) begin
            shadow[cfg_addr] <= cfg_data;
         end
      end
   end

`ifdef PAD_CTL_STAGGER_EN
   localparam int CNT_W = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;

   logic [AW-1:0] idx, idx_n;
   logic cnt_load, cnt_dec, cnt_zero, copy_en, step;

   pad_ctl_stagger_cnt #(.W(CNT_W)) u_stagger_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (CNT_W'(STAGGER_CYC - 1)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      pending_n = pending;
      done_n    = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      copy_en   = 1'b0;
      step      = 1'b0;
      if (busy && apply_req) begin
         pending_n = 1'b1;
      end
      case (state)
         IDLE: begin
            if (apply_req) begin
               state_n = SCAN;
               idx_n   = AW'(FIRST_PAD);
            end
         end
         SCAN: begin
            if (shadow[idx] != live[idx]) begin
               copy_en = 1'b1;
               if (STAGGER_CYC > 1) begin
                  cnt_load = 1'b1;
                  state_n  = WAIT;
               end else begin
                  step = 1'b1;
               end
            end else begin
               step = 1'b1;
            end
         end
         WAIT: begin
            cnt_dec = 1'b1;
            step    = cnt_zero;
         end
         default: state_n = IDLE;
      endcase
      // Advancing to the next pad happens on the SCAN/WAIT exit edge itself.
      if (step) begin
         if (idx == AW'(NUM_PADS - 1)) begin
            done_n = 1'b1;
            if (pend_eff) begin
               state_n   = SCAN;
               idx_n     = AW'(FIRST_PAD);
               pending_n = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end else begin
            idx_n   = idx + 1'b1;
            state_n = SCAN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         for (int p = FIRST_PAD; p < NUM_PADS; p++) begin
            live[p] <= RESET_CTL;
         end
      end else begin
         idx <= idx_n;
         if (copy_en) begin
            live[idx] <= shadow[idx];
         end
      end
   end
`else
   logic copy_all;

   always_comb begin
      state_n   = state;
      pending_n = pending;
      done_n    = 1'b0;
      copy_all  = 1'b0;
      if (busy && apply_req) begin
         pending_n = 1'b1;
      end
      case (state)
         IDLE: begin
            if (apply_req) begin
               state_n = SCAN;
            end
         end
         SCAN: begin
            copy_all = 1'b1;
            done_n   = 1'b1;
            if (pend_eff) begin
               state_n   = SCAN;
               pending_n = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = FIRST_PAD; p < NUM_PADS; p++) begin
            live[p] <= RESET_CTL;
         end
      end else if (copy_all) begin
         for (int p = FIRST_PAD; p < NUM_PADS; p++) begin
            live[p] <= shadow[p];
         end
      end
   end
`endif

   for (genvar p = FIRST_PAD; p < NUM_PADS; p++) begin : g_out
      assign pad_ctl_o[pad_ctl_offset(p, FIRST_PAD, PAD_CTL_W) +: PAD_CTL_W] = live[p];
   end

endmodule

// File: tb/tb_pad_ctl_scheduler.sv
// Bench for pad_ctl_scheduler: directed tables and sequences plus random traffic
// checked against a schedule-based model; follows PAD_CTL_STAGGER_EN like the DUT.
module tb_pad_ctl_scheduler;

   localparam int NP = 11;
   localparam int FP = 3;
   localparam int W  = 9;
   localparam int SC = 4;
   localparam int NC = NP - FP;
   localparam int OW = NC * W;
`ifdef PAD_CTL_STAGGER_EN
   localparam bit STAG = 1'b1;
`else
   localparam bit STAG = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, cfg_valid, cfg_ready, cfg_err, apply_req, busy, done;
   logic [3:0] cfg_addr;
   logic [W-1:0] cfg_data;
   logic [OW-1:0] pad_ctl_o;

   always #5 clk = ~clk;

   pad_ctl_scheduler #(
      .NUM_PADS    (NP),
      .FIRST_PAD   (FP),
      .PAD_CTL_W   (W),
      .STAGGER_CYC (SC),
      .RESET_CTL   (9'h000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err),
      .apply_req (apply_req),
      .busy      (busy),
      .done      (done),
      .pad_ctl_o (pad_ctl_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Model: shadow/live arrays plus a precomputed schedule of live updates.
   typedef struct {
      int cyc;
      int pad;
      logic [W-1:0] val;
   } ev_t;
   ev_t evq[$];
   logic [W-1:0] m_shadow[NP];
   logic [W-1:0] m_live[NP];
   int seq_start = 0;
   int seq_end = 0;
   bit pending = 0;
   bit e_busy = 0, e_done = 0, e_err = 0;

   logic ob_busy, ob_done, ob_err, ob_ready;
   logic [OW-1:0] ob_pad;

   typedef struct {
      logic [3:0] addr;
      logic [W-1:0] data;
      bit exp_err;
   } cfg_vec_t;
   cfg_vec_t tab[8];

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [OW-1:0] model_pad();
      logic [OW-1:0] v;
      v = '0;
      for (int p = FP; p < NP; p++) v[(p-FP)*W +: W] = m_live[p];
      return v;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_shadow[p] = '0;
         m_live[p] = '0;
      end
      evq.delete();
      seq_start = 0;
      seq_end = 0;
      pending = 0;
      e_busy = 0;
      e_done = 0;
      e_err = 0;
   endtask

   // First SCAN cycle s: a changed pad is visible one cycle after its scan
   // and occupies SC cycles; an unchanged pad occupies one cycle.
   task automatic start_seq(input int s);
      logic [W-1:0] tmp[NP];
      ev_t ev;
      int t;
      tmp = m_live;
      t = s;
      seq_start = s;
      for (int p = FP; p < NP; p++) begin
         if (m_shadow[p] !== tmp[p]) begin
            ev.cyc = STAG ? t + 1 : s + 1;
            ev.pad = p;
            ev.val = m_shadow[p];
            evq.push_back(ev);
            tmp[p] = m_shadow[p];
            t += STAG ? SC : 1;
         end else begin
            t += 1;
         end
      end
      seq_end = STAG ? t : s + 1;
   endtask

   task automatic model_step(input bit r, input bit v, input logic [3:0] a, input logic [W-1:0] d, input bit ap);
      int nxt;
      bit busy_now;
      nxt = cyc + 1;
      busy_now = e_busy;
      if (r) begin
         model_reset();
         return;
      end
      e_err = 0;
      if (v && !busy_now) begin
         if (a >= FP && a < NP) m_shadow[a] = d;
         else e_err = 1;
      end
      if (ap) begin
         if (busy_now) pending = 1;
         else start_seq(nxt);
      end
      for (int i = evq.size() - 1; i >= 0; i--) begin
         if (evq[i].cyc == nxt) begin
            m_live[evq[i].pad] = evq[i].val;
            evq.delete(i);
         end
      end
      e_done = (seq_end == nxt);
      if (e_done && pending) begin
         pending = 0;
         start_seq(nxt);
      end
      e_busy = (nxt >= seq_start) && (nxt < seq_end);
   endtask

   task automatic tick(input bit r, input bit v, input logic [3:0] a, input logic [W-1:0] d, input bit ap);
      @(negedge clk);
      ob_busy = busy;
      ob_done = done;
      ob_err = cfg_err;
      ob_ready = cfg_ready;
      ob_pad = pad_ctl_o;
      chk("pad_ctl_o", pad_ctl_o, model_pad());
      chk("busy", busy, e_busy);
      chk("cfg_ready", cfg_ready, !e_busy);
      chk("done", done, e_done);
      chk("cfg_err", cfg_err, e_err);
      rst = r;
      cfg_valid = v;
      cfg_addr = a;
      cfg_data = d;
      apply_req = ap;
      model_step(r, v, a, d, ap);
      cyc++;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 4'd0, '0, 1'b0);
   endtask

   task automatic write(input logic [3:0] a, input logic [W-1:0] d);
      tick(1'b0, 1'b1, a, d, 1'b0);
   endtask

   task automatic write_all(input logic [W-1:0] base);
      for (int p = FP; p < NP; p++) write(4'(p), base + W'(p * 7));
   endtask

   task automatic run_to_done(output int dn);
      dn = -1;
      for (int k = 1; k <= 80; k++) begin
         idle();
         if (ob_done) begin
            dn = k;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      int upd, dn, nb, nchg, first_chg, last_chg, ndone;
      logic [OW-1:0] prev;

      tab[0] = '{4'd1,  9'h055, 1'b1};
      tab[1] = '{4'd12, 9'h0AA, 1'b1};
      tab[2] = '{4'd3,  9'h0C3, 1'b0};
      tab[3] = '{4'd0,  9'h1FF, 1'b1};
      tab[4] = '{4'd15, 9'h123, 1'b1};
      tab[5] = '{4'd10, 9'h03C, 1'b0};
      tab[6] = '{4'd2,  9'h111, 1'b1};
      tab[7] = '{4'd11, 9'h0F0, 1'b1};

      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;
      apply_req = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();

      // Reset values
      idle();
      chk("reset_pad", ob_pad, '0);
      chk("reset_ready", ob_ready, 1'b1);
      chk("reset_busy", ob_busy, 1'b0);
      chk("reset_done", ob_done, 1'b0);

      // One changed pad, seven unchanged
      write(4'd3, 9'h1A5);
      tick(1'b0, 1'b0, 4'd0, '0, 1'b1);
      upd = -1; dn = -1; nb = 0;
      for (int k = 1; k <= 60; k++) begin
         idle();
         if (ob_busy) nb++;
         if (upd < 0 && ob_pad[W-1:0] == 9'h1A5) upd = k;
         if (ob_done) begin
            dn = k;
            break;
         end
      end
      chk("t1_update_cycle", upd, 2);
      chk("t1_done_cycle", dn, STAG ? 12 : 2);
      chk("t1_busy_cycles", nb, STAG ? 11 : 1);

      // All eight pads changed
      write_all(9'h100);
      tick(1'b0, 1'b0, 4'd0, '0, 1'b1);
      prev = ob_pad;
      dn = -1; nb = 0; nchg = 0; first_chg = -1; last_chg = -1;
      for (int k = 1; k <= 60; k++) begin
         idle();
         if (ob_busy) nb++;
         if (ob_pad !== prev) begin
            nchg++;
            if (first_chg < 0) first_chg = k;
            last_chg = k;
            prev = ob_pad;
         end
         if (ob_done) begin
            dn = k;
            break;
         end
      end
      chk("t2_change_count", nchg, STAG ? 8 : 1);
      chk("t2_first_update", first_chg, 2);
      chk("t2_last_update", last_chg, STAG ? 30 : 2);
      chk("t2_busy_cycles", nb, STAG ? 32 : 1);
      chk("t2_done_cycle", dn, STAG ? 33 : 2);

      // Config write table: out-of-range writes pulse cfg_err once, no effect
      for (int i = 0; i < 8; i++) begin
         write(tab[i].addr, tab[i].data);
         idle();
         chk("tab_cfg_err", ob_err, tab[i].exp_err);
         idle();
         chk("tab_cfg_err_clear", ob_err, 1'b0);
      end
      tick(1'b0, 1'b0, 4'd0, '0, 1'b1);
      run_to_done(dn);
      chk("tab_done_seen", dn > 0, 1'b1);
      chk("tab_pad3", ob_pad[0 +: W], 9'h0C3);
      chk("tab_pad10", ob_pad[7*W +: W], 9'h03C);
      chk("tab_pad4_kept", ob_pad[1*W +: W], 9'h100 + 9'd28);

      // Write and apply in the same idle cycle
      tick(1'b0, 1'b1, 4'd5, 9'h0F0, 1'b1);
      run_to_done(dn);
      chk("t4_done_seen", dn > 0, 1'b1);
      idle();
      chk("t4_pad5", ob_pad[2*W +: W], 9'h0F0);

      // Extra apply requests while busy collapse into one rerun
      write_all(9'h040);
      tick(1'b0, 1'b0, 4'd0, '0, 1'b1);
      ndone = 0;
      for (int k = 1; k <= 150; k++) begin
         tick(1'b0, 1'b0, 4'd0, '0, (k <= (STAG ? 3 : 1)));
         if (ob_done) ndone++;
      end
      chk("t5_done_pulses", ndone, 2);

      // Reset in cycle 10 of a sequence
      write_all(9'h0A0);
      tick(1'b0, 1'b0, 4'd0, '0, 1'b1);
      for (int k = 1; k <= 9; k++) idle();
      tick(1'b1, 1'b0, 4'd0, '0, 1'b0);
      idle();
      chk("t6_pad_reset", ob_pad, '0);
      chk("t6_busy_reset", ob_busy, 1'b0);
      chk("t6_ready_reset", ob_ready, 1'b1);
      chk("t6_done_reset", ob_done, 1'b0);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         idle();
         if (ob_done) ndone++;
      end
      chk("t6_no_done", ndone, 0);

      // Random traffic against the model
      for (int k = 0; k < 800; k++) begin
         tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
              4'($urandom_range(0, 15)), W'($urandom), ($urandom_range(0, 7) == 0));
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
